// File: rtl/exc_commit_ctrl.sv
// exc_commit_ctrl: exception / ERTN commit controller at the writeback boundary.
// Picks the highest-priority cause for the instruction in WB (interrupt first,
// then ADEF, INE, SYS, BRK, ALE, then ERTN). It issues the one-cycle commit
// strobes and their payload to the CSR file. It then flushes the pipeline for
// FLUSH_CYCLES cycles and holds a valid/ready redirect to IF until IF accepts it.
//
// Ports:
//   clk, resetn                  clock, synchronous active-low reset
//   ws_valid/ws_pc/ws_exc/       WB instruction: valid, PC, flags
//   ws_ertn/ws_badv                {ale,brk,sys,ine,adef}, ERTN, fault address
//   int_pending                  pre-masked interrupt request
//   csr_target_pc                CSR redirect target, valid in the commit cycle
//   exc_signal/ertn_signal       commit strobes (combinational, commit cycle only)
//   exc_ecode/exc_esubcode/      exception payload, valid with exc_signal
//   exc_pc
//   badv_we/badv                 BADV write for ADEF/ALE
//   flush                        kill in-flight stages (commit, DRAIN, REDIRECT)
//   redir_valid/redir_pc/        redirect handshake to IF
//   redir_ready
module exc_commit_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter bit          INT_EN       = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ws_valid,
    input  logic [31:0] ws_pc,
    input  logic [4:0]  ws_exc,
    input  logic        ws_ertn,
    input  logic [31:0] ws_badv,
    input  logic        int_pending,
    input  logic [31:0] csr_target_pc,
    output logic        exc_signal,
    output logic        ertn_signal,
    output logic [5:0]  exc_ecode,
    output logic [8:0]  exc_esubcode,
    output logic [31:0] exc_pc,
    output logic        badv_we,
    output logic [31:0] badv,
    output logic        flush,
    output logic        redir_valid,
    output logic [31:0] redir_pc,
    input  logic        redir_ready
);

    localparam int unsigned CNT_W = 4;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [31:0]        redir_pc_nxt;
    logic               int_take;
    logic               commit_ev;

    // Commit qualification; the resetn term keeps strobes quiet while in reset.
    assign int_take  = INT_EN && int_pending;
    assign commit_ev = resetn && ws_valid && (int_take || (|ws_exc) || ws_ertn);

    // State, drain counter and captured redirect target.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            cnt      <= '0;
            redir_pc <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            redir_pc <= redir_pc_nxt;
        end
    end

    // Next state, cause priority and commit/redirect outputs.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        redir_pc_nxt = redir_pc;
        exc_signal   = 1'b0;
        ertn_signal  = 1'b0;
        exc_ecode    = '0;
        exc_esubcode = '0;
        exc_pc       = '0;
        badv_we      = 1'b0;
        badv         = '0;
        flush        = 1'b0;
        redir_valid  = 1'b0;

        case (state)
            IDLE: begin
                if (commit_ev) begin
                    flush        = 1'b1;
                    state_nxt    = DRAIN;
                    cnt_nxt      = CNT_W'(FLUSH_CYCLES);
                    redir_pc_nxt = csr_target_pc;
                    if (int_take) begin
                        exc_signal = 1'b1;
                        exc_ecode  = ECODE_INT;
                    end else if (ws_exc[0]) begin
                        exc_signal = 1'b1;
                        exc_ecode  = ECODE_ADEF;
                        badv_we    = 1'b1;
                    end else if (ws_exc[1]) begin
                        exc_signal = 1'b1;
                        exc_ecode  = ECODE_INE;
                    end else if (ws_exc[2]) begin
                        exc_signal = 1'b1;
                        exc_ecode  = ECODE_SYS;
                    end else if (ws_exc[3]) begin
                        exc_signal = 1'b1;
                        exc_ecode  = ECODE_BRK;
                    end else if (ws_exc[4]) begin
                        exc_signal = 1'b1;
                        exc_ecode  = ECODE_ALE;
                        badv_we    = 1'b1;
                    end else begin
                        ertn_signal = 1'b1;
                    end
                    // Interrupted or faulting instruction is not retired: ERA is its own PC.
                    if (exc_signal) begin
                        exc_pc = ws_pc;
                    end
                    if (badv_we) begin
                        badv = ws_badv;
                    end
                end
            end
            DRAIN: begin
                flush   = 1'b1;
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = REDIRECT;
                end
            end
            REDIRECT: begin
                flush       = 1'b1;
                redir_valid = 1'b1;
                if (redir_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Self-checking bench for exc_commit_ctrl. Two instances share all inputs:
// dut_a uses defaults (FLUSH_CYCLES=1, INT_EN=1), dut_b uses FLUSH_CYCLES=3
// with interrupts disabled. Directed scenarios use hand-derived constants; the
// random scenario compares both instances against a timestamp-based model.
module tb_exc_commit_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ws_valid;
    logic [31:0] ws_pc;
    logic [4:0]  ws_exc;
    logic        ws_ertn;
    logic [31:0] ws_badv;
    logic        int_pending;
    logic [31:0] csr_target_pc;
    logic        redir_ready;

    logic        a_exc_signal, a_ertn_signal, a_badv_we, a_flush, a_redir_valid;
    logic [5:0]  a_exc_ecode;
    logic [8:0]  a_exc_esubcode;
    logic [31:0] a_exc_pc, a_badv, a_redir_pc;
    logic        b_exc_signal, b_ertn_signal, b_badv_we, b_flush, b_redir_valid;
    logic [5:0]  b_exc_ecode;
    logic [8:0]  b_exc_esubcode;
    logic [31:0] b_exc_pc, b_badv, b_redir_pc;

    logic [115:0] a_out, b_out;

    int n_vec = 0;
    int n_err = 0;

    // Model state: per instance, active flag, commit cycle and captured target.
    int          cyc = 0;
    bit          m_act [2] = '{1'b0, 1'b0};
    int          m_t0  [2] = '{0, 0};
    logic [31:0] m_rpc [2] = '{32'h0, 32'h0};

    // Cause table indexed by ws_exc bit: adef, ine, sys, brk, ale.
    logic [5:0]  code_tab [5] = '{6'h08, 6'h0D, 6'h0B, 6'h0C, 6'h09};

    // Priority sweep table.
    logic [4:0]  sw_pat  [5] = '{5'b10010, 5'b01100, 5'b11000, 5'b10000, 5'b10001};
    logic [5:0]  sw_code [5] = '{6'h0D, 6'h0B, 6'h0C, 6'h09, 6'h08};
    logic        sw_we   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    always #5 clk = ~clk;

    exc_commit_ctrl dut_a (
        .clk(clk), .resetn(resetn), .ws_valid(ws_valid), .ws_pc(ws_pc),
        .ws_exc(ws_exc), .ws_ertn(ws_ertn), .ws_badv(ws_badv),
        .int_pending(int_pending), .csr_target_pc(csr_target_pc),
        .exc_signal(a_exc_signal), .ertn_signal(a_ertn_signal),
        .exc_ecode(a_exc_ecode), .exc_esubcode(a_exc_esubcode), .exc_pc(a_exc_pc),
        .badv_we(a_badv_we), .badv(a_badv), .flush(a_flush),
        .redir_valid(a_redir_valid), .redir_pc(a_redir_pc), .redir_ready(redir_ready)
    );

    exc_commit_ctrl #(.FLUSH_CYCLES(3), .INT_EN(1'b0)) dut_b (
        .clk(clk), .resetn(resetn), .ws_valid(ws_valid), .ws_pc(ws_pc),
        .ws_exc(ws_exc), .ws_ertn(ws_ertn), .ws_badv(ws_badv),
        .int_pending(int_pending), .csr_target_pc(csr_target_pc),
        .exc_signal(b_exc_signal), .ertn_signal(b_ertn_signal),
        .exc_ecode(b_exc_ecode), .exc_esubcode(b_exc_esubcode), .exc_pc(b_exc_pc),
        .badv_we(b_badv_we), .badv(b_badv), .flush(b_flush),
        .redir_valid(b_redir_valid), .redir_pc(b_redir_pc), .redir_ready(redir_ready)
    );

    assign a_out = {a_exc_signal, a_ertn_signal, a_exc_ecode, a_exc_esubcode, a_exc_pc,
                    a_badv_we, a_badv, a_flush, a_redir_valid, a_redir_pc};
    assign b_out = {b_exc_signal, b_ertn_signal, b_exc_ecode, b_exc_esubcode, b_exc_pc,
                    b_badv_we, b_badv, b_flush, b_redir_valid, b_redir_pc};

    // Expected output vector for instance k given the current inputs and model state.
    function automatic logic [115:0] predict(int k);
        int          f;
        bit          ie;
        logic        ex, er, we, cm, rv;
        logic [5:0]  ec;
        logic [31:0] pc, bv;
        f  = (k == 0) ? 1 : 3;
        ie = (k == 0);
        ex = 1'b0; er = 1'b0; we = 1'b0; ec = 6'h0; pc = 32'h0; bv = 32'h0;
        cm = resetn && !m_act[k] && ws_valid &&
             ((ie && int_pending) || (ws_exc != 5'b0) || ws_ertn);
        if (cm) begin
            if (ie && int_pending) begin
                ex = 1'b1;
            end else if (ws_exc != 5'b0) begin
                ex = 1'b1;
                for (int b = 4; b >= 0; b--) begin
                    if (ws_exc[b]) begin
                        ec = code_tab[b];
                        we = (b == 0) || (b == 4);
                    end
                end
            end else begin
                er = 1'b1;
            end
        end
        if (ex) pc = ws_pc;
        if (we) bv = ws_badv;
        rv = m_act[k] && (cyc >= m_t0[k] + f + 1);
        return {ex, er, ec, 9'h0, pc, we, bv, (cm || m_act[k]), rv, m_rpc[k]};
    endfunction

    // Model update at each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                logic [115:0] p;
                p = predict(k);
                if (!resetn) begin
                    m_act[k] = 1'b0;
                    m_rpc[k] = 32'h0;
                end else if (p[115] || p[114]) begin
                    m_act[k] = 1'b1;
                    m_t0[k]  = cyc;
                    m_rpc[k] = csr_target_pc;
                end else if (p[32] && redir_ready) begin
                    m_act[k] = 1'b0;
                end
            end
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ws_valid    = 1'b0;
        ws_exc      = 5'b0;
        ws_ertn     = 1'b0;
        int_pending = 1'b0;
        redir_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 1'b0;
        tick();
        tick();
        @(negedge clk);
        n_vec++;
        if (a_out !== 116'h0) begin
            n_err++; $display("FAIL reset_a: got %h expected 0", a_out);
        end
        n_vec++;
        if (b_out !== 116'h0) begin
            n_err++; $display("FAIL reset_b: got %h expected 0", b_out);
        end
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_adef();
        do_reset();
        ws_valid = 1'b1; ws_pc = 32'h1C000004; ws_exc = 5'b00001;
        ws_badv = 32'h1C000004; csr_target_pc = 32'h1C008000; redir_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({a_exc_signal, a_ertn_signal, a_exc_ecode, a_exc_esubcode, a_badv_we, a_badv,
             a_exc_pc, a_flush, a_redir_valid} !==
            {1'b1, 1'b0, 6'h08, 9'h0, 1'b1, 32'h1C000004, 32'h1C000004, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL adef_commit: got exc=%b ertn=%b ecode=%h sub=%h we=%b badv=%h pc=%h flush=%b rv=%b expected 1 0 08 000 1 1c000004 1c000004 1 0",
                     a_exc_signal, a_ertn_signal, a_exc_ecode, a_exc_esubcode, a_badv_we,
                     a_badv, a_exc_pc, a_flush, a_redir_valid);
        end
        tick();
        ws_valid = 1'b0; ws_exc = 5'b0;
        @(negedge clk);
        n_vec++;
        if ({a_exc_signal, a_flush, a_redir_valid} !== 3'b010) begin
            n_err++; $display("FAIL adef_drain: got %b expected 010", {a_exc_signal, a_flush, a_redir_valid});
        end
        tick();
        @(negedge clk);
        n_vec++;
        if ({a_redir_valid, a_redir_pc, a_flush} !== {1'b1, 32'h1C008000, 1'b1}) begin
            n_err++; $display("FAIL adef_redirect: got rv=%b pc=%h flush=%b expected 1 1c008000 1",
                              a_redir_valid, a_redir_pc, a_flush);
        end
        tick();
        @(negedge clk);
        n_vec++;
        if ({a_flush, a_redir_valid} !== 2'b00) begin
            n_err++; $display("FAIL adef_done: got %b expected 00", {a_flush, a_redir_valid});
        end
        idle_inputs();
    endtask

    task automatic test_int_priority();
        do_reset();
        ws_valid = 1'b1; int_pending = 1'b1; ws_exc = 5'b00100; ws_ertn = 1'b1;
        ws_pc = 32'h1C000040; ws_badv = 32'hDEAD0000;
        @(negedge clk);
        n_vec++;
        if ({a_exc_signal, a_ertn_signal, a_exc_ecode, a_badv_we, a_exc_pc} !==
            {1'b1, 1'b0, 6'h00, 1'b0, 32'h1C000040}) begin
            n_err++; $display("FAIL int_wins: got exc=%b ertn=%b ecode=%h we=%b pc=%h expected 1 0 00 0 1c000040",
                              a_exc_signal, a_ertn_signal, a_exc_ecode, a_badv_we, a_exc_pc);
        end
        n_vec++;
        if ({b_exc_signal, b_ertn_signal, b_exc_ecode, b_badv_we} !== {1'b1, 1'b0, 6'h0B, 1'b0}) begin
            n_err++; $display("FAIL int_disabled_sys: got exc=%b ertn=%b ecode=%h we=%b expected 1 0 0b 0",
                              b_exc_signal, b_ertn_signal, b_exc_ecode, b_badv_we);
        end
        do_reset();
        ws_valid = 1'b1; int_pending = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({a_exc_signal, a_exc_ecode, a_flush} !== {1'b1, 6'h00, 1'b1}) begin
            n_err++; $display("FAIL int_alone: got %b expected 1 000000 1", {a_exc_signal, a_exc_ecode, a_flush});
        end
        n_vec++;
        if ({b_exc_signal, b_ertn_signal, b_flush} !== 3'b000) begin
            n_err++; $display("FAIL int_disabled_nocommit: got %b expected 000", {b_exc_signal, b_ertn_signal, b_flush});
        end
        do_reset();
        ws_valid = 1'b0; ws_exc = 5'b11111; ws_ertn = 1'b1; int_pending = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({a_exc_signal, a_ertn_signal, a_flush} !== 3'b000) begin
            n_err++; $display("FAIL novalid: got %b expected 000", {a_exc_signal, a_ertn_signal, a_flush});
        end
        idle_inputs();
    endtask

    task automatic test_priority_sweep();
        for (int i = 0; i < 5; i++) begin
            logic [31:0] bexp;
            do_reset();
            ws_valid = 1'b1; ws_exc = sw_pat[i]; ws_ertn = 1'b1;
            ws_badv = 32'h10000000 + 32'(i);
            bexp = sw_we[i] ? ws_badv : 32'h0;
            @(negedge clk);
            n_vec++;
            if ({a_exc_signal, a_ertn_signal, a_exc_ecode, a_badv_we, a_badv} !==
                {1'b1, 1'b0, sw_code[i], sw_we[i], bexp}) begin
                n_err++; $display("FAIL prio_%0d: got exc=%b ertn=%b ecode=%h we=%b badv=%h expected 1 0 %h %b %h",
                                  i, a_exc_signal, a_ertn_signal, a_exc_ecode, a_badv_we, a_badv,
                                  sw_code[i], sw_we[i], bexp);
            end
        end
        idle_inputs();
    endtask

    task automatic test_ertn_stall();
        do_reset();
        ws_valid = 1'b1; ws_ertn = 1'b1; ws_pc = 32'h1C000200; csr_target_pc = 32'h1C000100;
        @(negedge clk);
        n_vec++;
        if ({b_ertn_signal, b_exc_signal, b_flush, b_redir_valid} !== 4'b1010) begin
            n_err++; $display("FAIL ertn_commit: got %b expected 1010",
                              {b_ertn_signal, b_exc_signal, b_flush, b_redir_valid});
        end
        tick();
        ws_valid = 1'b0; ws_ertn = 1'b0; csr_target_pc = 32'hFFFF0000;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_vec++;
            if ({b_flush, b_redir_valid} !== 2'b10) begin
                n_err++; $display("FAIL ertn_drain_T+%0d: got %b expected 10", k, {b_flush, b_redir_valid});
            end
            tick();
        end
        for (int k = 4; k <= 7; k++) begin
            @(negedge clk);
            n_vec++;
            if ({b_redir_valid, b_redir_pc, b_flush} !== {1'b1, 32'h1C000100, 1'b1}) begin
                n_err++; $display("FAIL ertn_hold_T+%0d: got rv=%b pc=%h flush=%b expected 1 1c000100 1",
                                  k, b_redir_valid, b_redir_pc, b_flush);
            end
            tick();
        end
        redir_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({b_redir_valid, b_flush} !== 2'b11) begin
            n_err++; $display("FAIL ertn_handshake: got %b expected 11", {b_redir_valid, b_flush});
        end
        tick();
        redir_ready = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({b_redir_valid, b_flush, b_ertn_signal} !== 3'b000) begin
            n_err++; $display("FAIL ertn_idle: got %b expected 000", {b_redir_valid, b_flush, b_ertn_signal});
        end
        idle_inputs();
    endtask

    task automatic test_reset_in_redirect();
        do_reset();
        ws_valid = 1'b1; ws_exc = 5'b00100; csr_target_pc = 32'h1C000300;
        tick();
        idle_inputs();
        tick();
        @(negedge clk);
        n_vec++;
        if (a_redir_valid !== 1'b1) begin
            n_err++; $display("FAIL rst_pre_redirect: got %b expected 1", a_redir_valid);
        end
        tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        @(negedge clk);
        n_vec++;
        if (a_out !== 116'h0) begin
            n_err++; $display("FAIL rst_mid_redirect_a: got %h expected 0", a_out);
        end
        n_vec++;
        if (b_out !== 116'h0) begin
            n_err++; $display("FAIL rst_mid_drain_b: got %h expected 0", b_out);
        end
        tick();
        ws_valid = 1'b1; ws_exc = 5'b00100; ws_pc = 32'h1C000304;
        @(negedge clk);
        n_vec++;
        if ({a_exc_signal, a_exc_ecode, a_exc_pc} !== {1'b1, 6'h0B, 32'h1C000304}) begin
            n_err++; $display("FAIL rst_new_sys: got exc=%b ecode=%h pc=%h expected 1 0b 1c000304",
                              a_exc_signal, a_exc_ecode, a_exc_pc);
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        do_reset();
        ws_valid = 1'b1; ws_exc = 5'b00100; ws_pc = 32'h1C000400; redir_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({a_exc_signal, b_exc_signal} !== 2'b11) begin
            n_err++; $display("FAIL b2b_first: got %b expected 11", {a_exc_signal, b_exc_signal});
        end
        tick();
        @(negedge clk);
        n_vec++;
        if ({a_exc_signal, a_flush, b_exc_signal, b_flush} !== 4'b0101) begin
            n_err++; $display("FAIL ignore_in_drain: got %b expected 0101",
                              {a_exc_signal, a_flush, b_exc_signal, b_flush});
        end
        tick();
        @(negedge clk);
        n_vec++;
        if ({a_redir_valid, a_exc_signal} !== 2'b10) begin
            n_err++; $display("FAIL b2b_handshake: got %b expected 10", {a_redir_valid, a_exc_signal});
        end
        tick();
        @(negedge clk);
        n_vec++;
        if ({a_exc_signal, a_exc_ecode, b_exc_signal} !== {1'b1, 6'h0B, 1'b0}) begin
            n_err++; $display("FAIL b2b_second: got a_exc=%b ecode=%h b_exc=%b expected 1 0b 0",
                              a_exc_signal, a_exc_ecode, b_exc_signal);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            logic [115:0] ea, eb;
            resetn        = ($urandom_range(0, 63) != 0);
            ws_valid      = 1'($urandom_range(0, 1));
            ws_exc        = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'b0;
            ws_ertn       = ($urandom_range(0, 3) == 0);
            int_pending   = ($urandom_range(0, 4) == 0);
            ws_pc         = $urandom;
            ws_badv       = $urandom;
            csr_target_pc = $urandom;
            redir_ready   = 1'($urandom_range(0, 1));
            @(negedge clk);
            ea = predict(0);
            eb = predict(1);
            n_vec++;
            if (a_out !== ea) begin
                n_err++; $display("FAIL rand_a[%0d]: got %h expected %h", i, a_out, ea);
            end
            n_vec++;
            if (b_out !== eb) begin
                n_err++; $display("FAIL rand_b[%0d]: got %h expected %h", i, b_out, eb);
            end
            tick();
        end
        resetn = 1'b1;
        idle_inputs();
    endtask

    initial begin
        resetn = 1'b0;
        ws_pc = 32'h0; ws_badv = 32'h0; csr_target_pc = 32'h0;
        idle_inputs();
        test_reset();
        test_adef();
        test_int_priority();
        test_priority_sweep();
        test_ertn_stall();
        test_reset_in_redirect();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
